// File: rtl/bram_request_arbiter_if.sv
// Adder/BRAM bus seen by bram_request_arbiter.
// slave  : arbiter side (requests in, BRAM port controls out)
// master : environment side (adder requests and BRAM data)
interface bram_request_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned CNT_WIDTH = 16;

  logic                  read_valid_in;
  logic                  read_ready_out;
  logic [ADDR_WIDTH-1:0] x_pointer_in;
  logic [ADDR_WIDTH-1:0] y_pointer_in;
  logic                  data_valid_out;
  logic [DATA_WIDTH-1:0] x_data_out;
  logic [DATA_WIDTH-1:0] y_data_out;
  logic                  write_valid_in;
  logic [DATA_WIDTH-1:0] write_data_in;
  logic [ADDR_WIDTH-1:0] write_pointer_in;
  logic [ADDR_WIDTH-1:0] bram_read_addr_out;
  logic [DATA_WIDTH-1:0] bram_read_data_in;
  logic [ADDR_WIDTH-1:0] bram_write_addr_out;
  logic [DATA_WIDTH-1:0] bram_write_data_out;
  logic                  bram_we_out;
  logic [CNT_WIDTH-1:0]  collision_count_out;

  modport slave (
    input  read_valid_in, x_pointer_in, y_pointer_in,
    input  write_valid_in, write_data_in, write_pointer_in,
    input  bram_read_data_in,
    output read_ready_out, data_valid_out, x_data_out, y_data_out,
    output bram_read_addr_out, bram_write_addr_out, bram_write_data_out,
    output bram_we_out, collision_count_out
  );

  modport master (
    output read_valid_in, x_pointer_in, y_pointer_in,
    output write_valid_in, write_data_in, write_pointer_in,
    output bram_read_data_in,
    input  read_ready_out, data_valid_out, x_data_out, y_data_out,
    input  bram_read_addr_out, bram_write_addr_out, bram_write_data_out,
    input  bram_we_out, collision_count_out
  );
endinterface

// File: rtl/bram_request_arbiter.sv
// bram_request_arbiter: turns a paired x/y read request into two port-B
// reads returned together, forwards writes to port A, and stalls a read
// issue that would race a same-address write.
// Optional: define BRAM_ARB_COLLISION_CNT_EN to build the 16-bit saturating
// collision stall counter; otherwise collision_count_out is tied to 0.
module bram_request_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  bram_request_arbiter_if.slave bus
);
  localparam int unsigned RL = READ_LATENCY;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_X = 3'd1,
    ISSUE_Y = 3'd2,
    WAIT    = 3'd3,
    RETURN  = 3'd4
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] x_ptr;
  logic [ADDR_WIDTH-1:0] y_ptr;
  logic [DATA_WIDTH-1:0] x_buf;
  logic [RL-1:0]         x_pipe;
  logic [RL-1:0]         y_pipe;
  logic                  accept;
  logic                  issue_x;
  logic                  issue_y;
  logic                  collide_x;
  logic                  collide_y;
  logic                  x_done;
  logic                  y_done;

  // A read address is in flight for RL cycles; the top bit marks doutb valid.
  assign x_done = x_pipe[RL-1];
  assign y_done = y_pipe[RL-1];

  // A write to the address currently presented would land after the read
  // sample; holding one cycle lets the read see the new word.
  assign collide_x = bus.write_valid_in && (bus.write_pointer_in == x_ptr);
  assign collide_y = bus.write_valid_in && (bus.write_pointer_in == y_ptr);

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= next_state;
  end

  // Next-state and issue strobes.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue_x    = 1'b0;
    issue_y    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.read_ready_out && bus.read_valid_in) begin
          accept     = 1'b1;
          next_state = ISSUE_X;
        end
      end
      ISSUE_X: begin
        if (!collide_x) begin
          issue_x    = 1'b1;
          next_state = ISSUE_Y;
        end
      end
      ISSUE_Y: begin
        if (!collide_y) begin
          issue_y    = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (y_done) next_state = RETURN;
      end
      RETURN: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Read path: pointer latch, port-B address, in-flight tracking, result capture.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_ptr                  <= '0;
      y_ptr                  <= '0;
      x_buf                  <= '0;
      x_pipe                 <= '0;
      y_pipe                 <= '0;
      bus.read_ready_out     <= 1'b0;
      bus.data_valid_out     <= 1'b0;
      bus.x_data_out         <= '0;
      bus.y_data_out         <= '0;
      bus.bram_read_addr_out <= '0;
    end else begin
      bus.read_ready_out <= (next_state == IDLE);
      bus.data_valid_out <= y_done;
      x_pipe             <= RL'({x_pipe, issue_x});
      y_pipe             <= RL'({y_pipe, issue_y});
      if (accept) begin
        x_ptr                  <= bus.x_pointer_in;
        y_ptr                  <= bus.y_pointer_in;
        bus.bram_read_addr_out <= bus.x_pointer_in;
      end else if (issue_x) begin
        bus.bram_read_addr_out <= y_ptr;
      end
      if (x_done) x_buf <= bus.bram_read_data_in;
      if (y_done) begin
        bus.x_data_out <= x_buf;
        bus.y_data_out <= bus.bram_read_data_in;
      end
    end
  end

  // Write path: port A is dedicated, one-cycle registered forward.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.bram_we_out         <= 1'b0;
      bus.bram_write_addr_out <= '0;
      bus.bram_write_data_out <= '0;
    end else begin
      bus.bram_we_out <= bus.write_valid_in;
      if (bus.write_valid_in) begin
        bus.bram_write_addr_out <= bus.write_pointer_in;
        bus.bram_write_data_out <= bus.write_data_in;
      end
    end
  end

`ifdef BRAM_ARB_COLLISION_CNT_EN
  logic stall;
  assign stall = ((state == ISSUE_X) && collide_x) || ((state == ISSUE_Y) && collide_y);

  // Saturating count of stalled issue cycles, cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.collision_count_out <= '0;
    end else if (stall && (bus.collision_count_out != 16'hFFFF)) begin
      bus.collision_count_out <= bus.collision_count_out + 16'd1;
    end
  end
`else
  assign bus.collision_count_out = '0;
`endif

endmodule
